// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory access sequencer: FSM encoding, requester ids
// and the word-address legality check.
package mem_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_HOLD,
    S_DONE
  } state_t;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_D  = 1'b1;

  // A request is legal when word aligned and the whole word lies inside memory.
  function automatic logic addr_legal(input logic [63:0] addr, input logic [63:0] mem_bytes);
    return (addr[1:0] == 2'b00) && (addr <= mem_bytes - 64'd4);
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Fixed-priority 2:1 grant between the load/store port and the fetch port.
module mem_arbiter
  import mem_ctrl_pkg::*;
(
  input  logic if_req,
  input  logic d_req,
  output logic grant,
  output logic grant_id
);

  assign grant    = if_req | d_req;
  assign grant_id = d_req ? PORT_D : PORT_IF;

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequences fetch and load/store requests onto the shared word memory so that
// address/data settle a cycle before the strobe and stay put a cycle after it.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int MEM_BYTES     = 1024,
  parameter int ACCESS_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              err,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_data
);

  localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

  state_t             state;
  logic               port_id;
  logic               we;
  logic [CNT_W-1:0]   cnt;
  logic               grant;
  logic               grant_id;
  logic [ADDR_W-1:0]  sel_addr;
  logic               sel_store;
  logic               sel_ok;

  mem_arbiter u_arb (
    .if_req   (if_req),
    .d_req    (d_req),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign sel_addr  = (grant_id == PORT_D) ? d_addr : if_addr;
  assign sel_store = (grant_id == PORT_D) && d_we;
  assign sel_ok    = addr_legal(64'(sel_addr), 64'(MEM_BYTES));
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      port_id        <= PORT_IF;
      we             <= 1'b0;
      cnt            <= '0;
      mem_address    <= '0;
      mem_write_data <= '0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      if_rdata       <= '0;
      d_rdata        <= '0;
      if_ready       <= 1'b0;
      d_ready        <= 1'b0;
      err            <= 1'b0;
    end else begin
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      err      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant) begin
            port_id <= grant_id;
            if (sel_ok) begin
              we          <= sel_store;
              mem_address <= sel_addr;
              if (sel_store) mem_write_data <= d_wdata;
              state       <= S_SETUP;
            end else begin
              // Illegal request: report immediately, memory pins untouched.
              err <= 1'b1;
              if (grant_id == PORT_D) d_ready <= 1'b1;
              else                    if_ready <= 1'b1;
              state <= S_DONE;
            end
          end
        end
        S_SETUP: begin
          cnt       <= CNT_W'(ACCESS_CYCLES - 1);
          mem_read  <= ~we;
          mem_write <= we;
          state     <= S_ACCESS;
        end
        S_ACCESS: begin
          if (cnt == '0) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            if (!we) begin
              if (port_id == PORT_D) d_rdata <= mem_data;
              else                   if_rdata <= mem_data;
            end
            state <= S_HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_HOLD: begin
          if (port_id == PORT_D) d_ready <= 1'b1;
          else                   if_ready <= 1'b1;
          state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: one instance with single-cycle access and
// one with a three-cycle access, each backed by a small word memory model.
module tb_mem_access_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance with default timing
  logic        if_req0, d_req0, d_we0;
  logic [31:0] if_addr0, d_addr0, d_wdata0;
  logic        if_ready0, d_ready0, err0, busy0, mem_read0, mem_write0;
  logic [31:0] if_rdata0, d_rdata0, mem_address0, mem_write_data0, mem_data0;
  logic [31:0] mem0 [0:255];

  mem_access_ctrl dut0 (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req0), .if_addr(if_addr0), .if_ready(if_ready0), .if_rdata(if_rdata0),
    .d_req(d_req0), .d_we(d_we0), .d_addr(d_addr0), .d_wdata(d_wdata0),
    .d_ready(d_ready0), .d_rdata(d_rdata0), .err(err0), .busy(busy0),
    .mem_address(mem_address0), .mem_write_data(mem_write_data0),
    .mem_read(mem_read0), .mem_write(mem_write0), .mem_data(mem_data0)
  );

  assign mem_data0 = mem0[mem_address0[9:2]];
  always @(posedge clk) if (mem_write0) mem0[mem_address0[9:2]] <= mem_write_data0;

  // Instance with a three-cycle strobe
  logic        if_req3, d_req3, d_we3;
  logic [31:0] if_addr3, d_addr3, d_wdata3;
  logic        if_ready3, d_ready3, err3, busy3, mem_read3, mem_write3;
  logic [31:0] if_rdata3, d_rdata3, mem_address3, mem_write_data3, mem_data3;
  logic [31:0] mem3 [0:255];

  mem_access_ctrl #(.ACCESS_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req3), .if_addr(if_addr3), .if_ready(if_ready3), .if_rdata(if_rdata3),
    .d_req(d_req3), .d_we(d_we3), .d_addr(d_addr3), .d_wdata(d_wdata3),
    .d_ready(d_ready3), .d_rdata(d_rdata3), .err(err3), .busy(busy3),
    .mem_address(mem_address3), .mem_write_data(mem_write_data3),
    .mem_read(mem_read3), .mem_write(mem_write3), .mem_data(mem_data3)
  );

  assign mem_data3 = mem3[mem_address3[9:2]];
  always @(posedge clk) if (mem_write3) mem3[mem_address3[9:2]] <= mem_write_data3;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One request on dut0; cycle k is the cycle after edge k-1, edge 0 samples the request.
  task automatic do_access(input logic is_d, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, output int rdy_cyc, output int rd_first,
                           output int rd_cnt, output int wr_cnt, output logic e,
                           output logic [31:0] a1, output logic stable);
    rdy_cyc = -1; rd_first = -1; rd_cnt = 0; wr_cnt = 0; e = 1'b0; a1 = '0; stable = 1'b1;
    @(posedge clk); #1;
    if (is_d) begin d_req0 = 1'b1; d_we0 = we; d_addr0 = addr; d_wdata0 = wdata; end
    else begin if_req0 = 1'b1; if_addr0 = addr; end
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); @(negedge clk);
      if (mem_read0) begin if (rd_first < 0) rd_first = k; rd_cnt++; end
      if (mem_write0) wr_cnt++;
      if (k == 1) a1 = mem_address0;
      else if (k <= 3 && mem_address0 !== a1) stable = 1'b0;
      if ((is_d && d_ready0) || (!is_d && if_ready0)) begin
        rdy_cyc = k; e = err0;
        d_req0 = 1'b0; if_req0 = 1'b0;
        break;
      end
    end
    d_req0 = 1'b0; if_req0 = 1'b0;
  endtask

  int rdy, rdf, rdc, wrc, d_rdy, i_rdy;
  logic e, st;
  logic [31:0] a1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) begin mem0[i] = '0; mem3[i] = '0; end
    mem0[32]  = 32'h16110003;  // 0x80
    mem0[33]  = 32'h8C020004;  // 0x84
    mem0[1]   = 32'h00000004;  // 0x04
    mem0[255] = 32'hCAFEF00D;  // 0x3FC
    mem3[32]  = 32'h16110003;
    if_req0 = 0; d_req0 = 0; d_we0 = 0; if_addr0 = 0; d_addr0 = 0; d_wdata0 = 0;
    if_req3 = 0; d_req3 = 0; d_we3 = 0; if_addr3 = 0; d_addr3 = 0; d_wdata3 = 0;
    rst_n = 1'b0;
    #22;
    check("rst_busy", 32'(busy0), 0);
    check("rst_maddr", mem_address0, 0);
    check("rst_strobes", {30'd0, mem_read0, mem_write0}, 0);
    check("rst_rdata", if_rdata0 | d_rdata0, 0);
    @(negedge clk); rst_n = 1'b1;

    // Reset dropped in the middle of a read access
    @(posedge clk); #1; if_req0 = 1'b1; if_addr0 = 32'h80;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    check("mid_rd_strobe", 32'(mem_read0), 1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_read", 32'(mem_read0), 0);
    check("mid_rst_busy", 32'(busy0), 0);
    check("mid_rst_ready", 32'(if_ready0), 0);
    check("mid_rst_maddr", mem_address0, 0);
    if_req0 = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk); rst_n = 1'b1;

    // Fetch 0x80
    do_access(1'b0, 1'b0, 32'h80, 0, rdy, rdf, rdc, wrc, e, a1, st);
    check("fetch_rdy_cyc", 32'(rdy), 4);
    check("fetch_rd_first", 32'(rdf), 2);
    check("fetch_rd_cnt", 32'(rdc), 1);
    check("fetch_rdata", if_rdata0, 32'h16110003);
    check("fetch_err", 32'(e), 0);

    // Store then load 0x0
    do_access(1'b1, 1'b1, 32'h0, 32'h00000001, rdy, rdf, rdc, wrc, e, a1, st);
    check("store_rdy_cyc", 32'(rdy), 4);
    check("store_wr_cnt", 32'(wrc), 1);
    check("store_rd_cnt", 32'(rdc), 0);
    check("store_addr", a1, 32'h0);
    check("store_addr_stable", 32'(st), 1);
    check("store_mem", mem0[0], 32'h00000001);
    do_access(1'b1, 1'b0, 32'h0, 0, rdy, rdf, rdc, wrc, e, a1, st);
    check("load_rdy_cyc", 32'(rdy), 4);
    check("load_rdata", d_rdata0, 32'h00000001);

    // Simultaneous load and fetch: load wins, fetch follows back-to-back
    @(posedge clk); #1;
    d_req0 = 1'b1; d_we0 = 1'b0; d_addr0 = 32'h4; if_req0 = 1'b1; if_addr0 = 32'h84;
    d_rdy = -1; i_rdy = -1;
    for (int k = 1; k <= 25; k++) begin
      @(posedge clk); @(negedge clk);
      if (d_ready0) begin d_rdy = k; d_req0 = 1'b0; end
      if (if_ready0) begin i_rdy = k; if_req0 = 1'b0; break; end
    end
    d_req0 = 1'b0; if_req0 = 1'b0;
    check("arb_d_rdy", 32'(d_rdy), 4);
    check("arb_if_rdy", 32'(i_rdy), 9);
    check("arb_d_rdata", d_rdata0, 32'h00000004);
    check("arb_if_rdata", if_rdata0, 32'h8C020004);

    // Illegal addresses, then the last legal word
    do_access(1'b1, 1'b0, 32'h06, 0, rdy, rdf, rdc, wrc, e, a1, st);
    check("misal_rdy_cyc", 32'(rdy), 1);
    check("misal_err", 32'(e), 1);
    check("misal_strobes", 32'(rdc + wrc), 0);
    check("misal_rdata_kept", d_rdata0, 32'h00000004);
    do_access(1'b1, 1'b0, 32'h3FE, 0, rdy, rdf, rdc, wrc, e, a1, st);
    check("oor_rdy_cyc", 32'(rdy), 1);
    check("oor_err", 32'(e), 1);
    check("oor_strobes", 32'(rdc + wrc), 0);
    do_access(1'b1, 1'b0, 32'h3FC, 0, rdy, rdf, rdc, wrc, e, a1, st);
    check("last_rdy_cyc", 32'(rdy), 4);
    check("last_err", 32'(e), 0);
    check("last_rdata", d_rdata0, 32'hCAFEF00D);

    // Three-cycle strobe instance
    @(posedge clk); #1; if_req3 = 1'b1; if_addr3 = 32'h80;
    rdy = -1; rdf = -1; rdc = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); @(negedge clk);
      if (mem_read3) begin if (rdf < 0) rdf = k; rdc++; end
      if (if_ready3) begin rdy = k; e = err3; if_req3 = 1'b0; break; end
    end
    if_req3 = 1'b0;
    check("ac3_rd_first", 32'(rdf), 2);
    check("ac3_rd_cnt", 32'(rdc), 3);
    check("ac3_rdy_cyc", 32'(rdy), 6);
    check("ac3_rdata", if_rdata3, 32'h16110003);
    check("ac3_err", 32'(e), 0);

    @(posedge clk); @(posedge clk); @(negedge clk);
    check("end_idle", {30'd0, busy0, busy3}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
